// File: rtl/crc16_framer.sv
// crc16_framer: forwards payload bytes from a source to the link, then
// appends the 16-bit CRC produced by the upstream crc16 engine as two
// trailer bytes. It also drives the engine's update and clear strobes,
// caps the frame length at MAX_LEN and enforces an inter-frame gap.
module crc16_framer #(
  parameter int GAP_CYCLES    = 2,
  parameter int MAX_LEN       = 1024,
  parameter bit CRC_MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic [15:0] crc_in,
  output logic        crc_en,
  output logic        crc_clr,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] frame_cnt,
  output logic        err_len
);

  // Byte counter must be able to hold MAX_LEN itself; gap counter must hold GAP_CYCLES.
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_GAP    = 3'd0,
    S_IDLE   = 3'd1,
    S_DATA   = 3'd2,
    S_CRC_HI = 3'd3,
    S_CRC_LO = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [CW-1:0]   cnt_q, cnt_d, new_cnt;
  logic [7:0]      hold_q, hold_d;
  logic [7:0]      data_d;
  logic            vld_d, last_d, err_d;
  logic [15:0]     fcnt_d;
  logic            slot_free, accept;

  // The output register can take a new byte when empty or draining this cycle.
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = ((state_q == S_IDLE) || (state_q == S_DATA)) && slot_free;
  assign accept    = in_valid && in_ready;
  assign crc_en    = accept;
  assign crc_clr   = (state_q == S_GAP);
  // First byte of a frame restarts the count at 1.
  assign new_cnt   = (state_q == S_IDLE) ? CW'(1) : cnt_q + CW'(1);

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    data_d  = out_data;
    vld_d   = out_valid && !out_ready;
    last_d  = out_last && !out_ready;
    fcnt_d  = frame_cnt;
    err_d   = 1'b0;
    case (state_q)
      S_GAP: begin
        // Gap runs regardless of whether the final CRC byte has drained.
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) state_d = S_IDLE;
      end
      S_IDLE, S_DATA: begin
        if (accept) begin
          data_d  = in_data;
          vld_d   = 1'b1;
          last_d  = 1'b0;
          cnt_d   = new_cnt;
          state_d = S_DATA;
          if (in_last || (new_cnt == CW'(MAX_LEN))) begin
            state_d = S_CRC_HI;
            err_d   = !in_last;
          end
        end
      end
      S_CRC_HI: begin
        // The engine's crc_code is only settled from this cycle on.
        if (slot_free) begin
          data_d  = CRC_MSB_FIRST ? crc_in[15:8] : crc_in[7:0];
          hold_d  = CRC_MSB_FIRST ? crc_in[7:0]  : crc_in[15:8];
          vld_d   = 1'b1;
          last_d  = 1'b0;
          state_d = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        if (slot_free) begin
          data_d  = hold_q;
          vld_d   = 1'b1;
          last_d  = 1'b1;
          fcnt_d  = frame_cnt + 16'd1;
          gap_d   = GW'(GAP_CYCLES);
          state_d = S_GAP;
        end
      end
      default: state_d = S_GAP;
    endcase
  end

  // State and output registers; reset parks the block in the gap so the engine is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_GAP;
      gap_q     <= GW'(GAP_CYCLES);
      cnt_q     <= '0;
      hold_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_cnt <= '0;
      err_len   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      out_data  <= data_d;
      out_valid <= vld_d;
      out_last  <= last_d;
      frame_cnt <= fcnt_d;
      err_len   <= err_d;
    end
  end

endmodule

// File: tb/tb_crc16_framer.sv
// Directed bench for crc16_framer. Two instances: u0 (MSB-first, MAX_LEN=4)
// and u1 (LSB-first, MAX_LEN=1024); sel routes stimulus/observation.
`timescale 1ns/1ps
module tb_crc16_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] crc_in = 16'h0000;
  logic        out_ready = 1'b1;
  logic        sel = 1'b0;
  logic        bp_mode = 1'b0;
  logic [15:0] crc_val = 16'h0000;

  logic        ir0, ce0, cc0, ov0, ol0, el0, ir1, ce1, cc1, ov1, ol1, el1;
  logic [7:0]  od0, od1;
  logic [15:0] fc0, fc1;
  logic        iv0, iv1;

  assign iv0 = in_valid && !sel;
  assign iv1 = in_valid && sel;

  crc16_framer #(.GAP_CYCLES(2), .MAX_LEN(4), .CRC_MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv0), .in_last(in_last),
    .in_ready(ir0), .crc_in(crc_in), .crc_en(ce0), .crc_clr(cc0), .out_data(od0),
    .out_valid(ov0), .out_last(ol0), .out_ready(out_ready), .frame_cnt(fc0), .err_len(el0));

  crc16_framer #(.GAP_CYCLES(2), .MAX_LEN(1024), .CRC_MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv1), .in_last(in_last),
    .in_ready(ir1), .crc_in(crc_in), .crc_en(ce1), .crc_clr(cc1), .out_data(od1),
    .out_valid(ov1), .out_last(ol1), .out_ready(out_ready), .frame_cnt(fc1), .err_len(el1));

  logic        m_in_ready, m_crc_en, m_crc_clr, m_out_valid, m_out_last, m_err_len;
  logic [7:0]  m_out_data;
  logic [15:0] m_frame_cnt;
  assign m_in_ready  = sel ? ir1 : ir0;
  assign m_crc_en    = sel ? ce1 : ce0;
  assign m_crc_clr   = sel ? cc1 : cc0;
  assign m_out_valid = sel ? ov1 : ov0;
  assign m_out_last  = sel ? ol1 : ol0;
  assign m_err_len   = sel ? el1 : el0;
  assign m_out_data  = sel ? od1 : od0;
  assign m_frame_cnt = sel ? fc1 : fc0;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: everything sampled on the falling edge, away from the active edge.
  logic [7:0] cap_d[$];
  logic       cap_l[$];
  int         acc_cyc[$];
  int         cyc = 0, en_cnt = 0, clr_cnt = 0, err_cnt = 0, last_cnt = 0;
  int         bp_viol = 0, stab_viol = 0;
  logic       prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       eng_en = 1'b0, eng_last = 1'b0, eng_clr = 1'b0;
  logic [7:0] eng_data = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (m_out_valid && out_ready) begin
      cap_d.push_back(m_out_data);
      cap_l.push_back(m_out_last);
      if (m_out_last) last_cnt++;
    end
    if (m_crc_en) begin
      en_cnt++;
      acc_cyc.push_back(cyc);
    end
    if (m_crc_clr) clr_cnt++;
    if (m_err_len) err_cnt++;
    if (m_out_valid && !out_ready && m_in_ready) bp_viol++;
    if (prev_stall && (m_out_data !== prev_data || !m_out_valid || m_out_last !== prev_last))
      stab_viol++;
    prev_stall = m_out_valid && !out_ready;
    prev_data  = m_out_data;
    prev_last  = m_out_last;
    eng_en     = m_crc_en;
    eng_last   = in_last;
    eng_data   = in_data;
    eng_clr    = m_crc_clr;
  end

  // Engine model: registers a code on the edge after crc_en. Non-final bytes
  // give a byte-dependent intermediate code so early sampling shows up.
  always @(posedge clk) begin
    if (eng_clr) crc_in <= 16'h0000;
    else if (eng_en) crc_in <= eng_last ? crc_val : {eng_data, ~eng_data};
  end

  // Downstream ready: always high, or toggling each cycle for backpressure.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp_mode ? !out_ready : 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  int cb, eb, clb, erb, ab, lb;
  logic [7:0] exp_d[$];
  logic       exp_l[$];

  task automatic mark();
    cb = cap_d.size(); eb = en_cnt; clb = clr_cnt; erb = err_cnt;
    ab = acc_cyc.size(); lb = last_cnt;
    exp_d.delete(); exp_l.delete();
  endtask

  task automatic ex(input logic [7:0] d, input logic l);
    exp_d.push_back(d);
    exp_l.push_back(l);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    in_data = d; in_valid = 1'b1; in_last = l;
    @(negedge clk);
    while (!m_in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("send_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while ((last_cnt - lb) < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("frame_done", 32'(last_cnt - lb), 32'(n));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic cmp_frame(input string tag);
    check({tag, "_len"}, 32'(cap_d.size() - cb), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && (cb + i) < cap_d.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i), 32'(cap_d[cb+i]), 32'(exp_d[i]));
      check($sformatf("%s_l%0d", tag, i), 32'(cap_l[cb+i]), 32'(exp_l[i]));
    end
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(m_out_valid), 32'd0);
    check("rst_out_last",  32'(m_out_last),  32'd0);
    check("rst_out_data",  32'(m_out_data),  32'd0);
    check("rst_in_ready",  32'(m_in_ready),  32'd0);
    check("rst_crc_en",    32'(m_crc_en),    32'd0);
    check("rst_crc_clr",   32'(m_crc_clr),   32'd1);
    check("rst_frame_cnt", 32'(m_frame_cnt), 32'd0);
    check("rst_err_len",   32'(m_err_len),   32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic frame
    mark(); crc_val = 16'h1D0F;
    send(8'hB6, 1'b0);
    check("t1_lat_data",  32'(m_out_data),  32'hB6);
    check("t1_lat_valid", 32'(m_out_valid), 32'd1);
    clb = clr_cnt;
    send(8'h4C, 1'b0);
    send(8'hB3, 1'b1);
    check("t1_last_pl", 32'(m_out_data), 32'hB3);
    @(posedge clk); #1;
    check("t1_crc_lat", 32'(m_out_data), 32'h1D);
    wait_done(1);
    ex(8'hB6, 0); ex(8'h4C, 0); ex(8'hB3, 0); ex(8'h1D, 0); ex(8'h0F, 1);
    cmp_frame("t1");
    check("t1_crc_en_cnt", 32'(en_cnt - eb),  32'd3);
    check("t1_frame_cnt",  32'(m_frame_cnt),  32'd1);
    check("t1_clr_cycles", 32'(clr_cnt - clb), 32'd2);

    // Backpressure
    mark(); crc_val = 16'h1D0F; bp_mode = 1'b1;
    send(8'hB6, 1'b0); send(8'h4C, 1'b0); send(8'hB3, 1'b1);
    wait_done(1);
    bp_mode = 1'b0;
    ex(8'hB6, 0); ex(8'h4C, 0); ex(8'hB3, 0); ex(8'h1D, 0); ex(8'h0F, 1);
    cmp_frame("t2");
    check("t2_crc_en_cnt", 32'(en_cnt - eb), 32'd3);
    check("t2_frame_cnt",  32'(m_frame_cnt), 32'd2);

    // Truncation at MAX_LEN=4, then remainder as a new frame
    mark(); crc_val = 16'h1234;
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    check("t3_err_pulses", 32'(err_cnt - erb), 32'd1);
    send(8'h07, 1'b1);
    wait_done(2);
    ex(8'h01, 0); ex(8'h02, 0); ex(8'h03, 0); ex(8'h04, 0); ex(8'h04, 0); ex(8'hFB, 1);
    ex(8'h05, 0); ex(8'h06, 0); ex(8'h07, 0); ex(8'h12, 0); ex(8'h34, 1);
    cmp_frame("t3");
    check("t3_err_total",  32'(err_cnt - erb), 32'd1);
    check("t3_gap_accept", 32'(acc_cyc[ab+4] - acc_cyc[ab+3]), 32'd5);
    check("t3_frame_cnt",  32'(m_frame_cnt), 32'd4);

    // Back-to-back single-byte frames
    mark(); crc_val = 16'h5A01;
    send(8'h81, 1'b1);
    crc_val = 16'h3C02;
    clb = clr_cnt;
    send(8'h0F, 1'b1);
    check("t4_clr_between", 32'(clr_cnt - clb), 32'd2);
    check("t4_accept_gap",  32'(acc_cyc[ab+1] - acc_cyc[ab]), 32'd5);
    check("t4_frame_cnt_a", 32'(m_frame_cnt), 32'd5);
    wait_done(2);
    ex(8'h81, 0); ex(8'h5A, 0); ex(8'h01, 1); ex(8'h0F, 0); ex(8'h3C, 0); ex(8'h02, 1);
    cmp_frame("t4");
    check("t4_frame_cnt_b", 32'(m_frame_cnt), 32'd6);

    // Asynchronous reset mid-frame
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(m_out_valid), 32'd0);
    check("t5_rst_fcnt",  32'(m_frame_cnt), 32'd0);
    check("t5_rst_clr",   32'(m_crc_clr),   32'd1);
    check("t5_rst_ready", 32'(m_in_ready),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mark(); crc_val = 16'hBEEF;
    send(8'h33, 1'b1);
    wait_done(1);
    ex(8'h33, 0); ex(8'hBE, 0); ex(8'hEF, 1);
    cmp_frame("t5");
    check("t5_frame_cnt", 32'(m_frame_cnt), 32'd1);

    // LSB-first trailer on u1
    sel = 1'b1;
    @(posedge clk); #1;
    mark(); crc_val = 16'hA5C3;
    send(8'h5E, 1'b1);
    wait_done(1);
    ex(8'h5E, 0); ex(8'hC3, 0); ex(8'hA5, 1);
    cmp_frame("t6");
    check("t6_frame_cnt", 32'(m_frame_cnt), 32'd1);

    check("bp_in_ready", 32'(bp_viol),   32'd0);
    check("bp_stable",   32'(stab_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc16_framer.md
Name: crc16_framer

Overview:
Byte-stream packet framer that sits directly downstream of the crc16 engine and also drives that engine's control inputs. It forwards payload bytes to the link, then appends the 16-bit CRC that the engine produced as two trailer bytes. It enforces a maximum frame length and an inter-frame gap, and it clears the engine between frames.

Parameters:
GAP_CYCLES, 2, idle cycles after a frame during which crc_clr is high and no input is accepted (must be >= 1)
MAX_LEN, 1024, maximum payload bytes per frame; the byte that reaches this count is forced to be the last byte
CRC_MSB_FIRST, 1, 1 = crc[15:8] is sent first, 0 = crc[7:0] is sent first

Ports:
clk  input  1  system clock, all flops on posedge
rst_n  input  1  asynchronous active-low reset
in_data  input  8  payload byte
in_valid  input  1  in_data is valid
in_last  input  1  final payload byte of the frame
in_ready  output  1  framer can accept a byte (combinational)
crc_in  input  16  crc_code from the crc16 engine
crc_en  output  1  engine update strobe; high in the cycle a payload byte is accepted (combinational)
crc_clr  output  1  engine clear; high while in GAP (combinational from state)
out_data  output  8  framed byte, registered
out_valid  output  1  out_data is valid, registered
out_last  output  1  final CRC byte of the frame, registered
out_ready  input  1  downstream accepts out_data
frame_cnt  output  16  count of completed frames, wraps from 16'hFFFF to 0
err_len  output  1  one-cycle pulse when a frame is truncated at MAX_LEN

Behaviour:
- Output slot: slot_free = !out_valid || out_ready.
- out_valid clears when out_ready is high and no new byte is loaded in that cycle.
- States: GAP, IDLE, DATA, CRC_HI, CRC_LO.
- Reset (async, any time, including mid-frame):
  - state = GAP, gap counter = GAP_CYCLES, byte count = 0, crc hold = 0.
  - out_data = 0, out_valid = 0, out_last = 0, frame_cnt = 0, err_len = 0.
  - Hence in_ready = 0, crc_en = 0, crc_clr = 1.
- in_ready = (state == IDLE || state == DATA) && slot_free.
- Accept = in_valid && in_ready; crc_en = accept.
- On accept:
  - out_data <= in_data, out_valid <= 1, out_last <= 0, byte count increments.
  - IDLE -> DATA on the first byte; the first byte resets byte count to 1.
- End of payload: an accepted byte ends the payload if in_last = 1 or the new byte count equals MAX_LEN.
  - Next state is CRC_HI.
  - If the count hit MAX_LEN without in_last, err_len pulses for 1 cycle at the following edge.
- Engine timing contract:
  - The engine registers crc_code on the edge after crc_en.
  - crc_in is therefore valid from the first CRC_HI cycle.
  - The framer samples crc_in no earlier than that cycle; the engine holds its value because crc_en = 0.
- CRC_HI: when slot_free:
  - out_data <= first CRC byte (per CRC_MSB_FIRST), out_valid <= 1.
  - Latch the other byte into the hold register; go to CRC_LO.
  - CRC_HI lasts at least 1 cycle even if the slot is free.
- CRC_LO: when slot_free:
  - out_data <= hold byte, out_valid <= 1, out_last <= 1.
  - frame_cnt increments; gap counter = GAP_CYCLES; go to GAP.
- GAP:
  - crc_clr = 1 and in_ready = 0.
  - The counter decrements each cycle; at count == 1 go to IDLE.
  - The pending last byte may still be waiting on out_ready; GAP proceeds independently of it.
- Backpressure: with out_ready = 0, out_data, out_valid and out_last hold stable, and no state advances except GAP.
- in_last is not forwarded. out_last is high only on the final CRC byte.
- in_last or in_valid while in_ready = 0 are ignored; the source must hold them.
- Minimum latency: payload byte to out_valid is 1 cycle. Last payload byte accept to the first CRC byte on out_data is 2 edges.

Test Plan:
- Basic frame, GAP_CYCLES = 2, out_ready = 1: reset, then bytes B6, 4C, B3 (in_last on B3); bench engine model presents crc_in = 16'h1D0F after B3.
  -> out bytes B6, 4C, B3, 1D, 0F with out_last only on 0F; crc_en high exactly 3 cycles; frame_cnt = 1; crc_clr high for 2 cycles after 0F is loaded.
- Backpressure: same frame with out_ready low on alternate cycles.
  -> identical byte sequence; in_ready = 0 whenever out_valid && !out_ready; no byte lost or duplicated.
- LSB-first, CRC_MSB_FIRST = 0, crc_in = 16'hA5C3.
  -> trailer bytes C3 then A5, out_last on A5.
- Truncation, MAX_LEN = 4: 6 bytes 01..06 with no in_last.
  -> out 01, 02, 03, 04, crc_hi, crc_lo; err_len pulses once; 05 is accepted only after the GAP as a new frame.
- Back-to-back frames 81 (last) then 0F (last).
  -> exactly GAP_CYCLES cycles with in_ready = 0 and crc_clr = 1 between them; frame_cnt increments 1 -> 2.
- Reset mid-frame: assert rst_n = 0 asynchronously after 2 payload bytes.
  -> out_valid = 0, frame_cnt = 0 and crc_clr = 1 immediately; after release the next frame is framed correctly.
